// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: width codes used by both the load and
// store paths, and the load unit's state encoding.
package mem_pkg;

    localparam logic [2:0] MW_NONE = 3'b000;
    localparam logic [2:0] MW_LD   = 3'b001;
    localparam logic [2:0] MW_LW   = 3'b010;
    localparam logic [2:0] MW_LH   = 3'b011;
    localparam logic [2:0] MW_LB   = 3'b100;
    localparam logic [2:0] MW_LWU  = 3'b101;
    localparam logic [2:0] MW_LHU  = 3'b110;
    localparam logic [2:0] MW_LBU  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } ld_state_e;

endpackage

// File: rtl/load_extract.sv
// Combinational field extraction and sign/zero extension of a 64-bit memory
// word, plus the natural-alignment check for the selected width.
module load_extract
    import mem_pkg::*;
(
    input  logic [63:0] mem_rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  memdata_width,
    output logic [63:0] ext_data,
    output logic        misaligned
);

    logic [7:0]  byte_f;
    logic [15:0] half_f;
    logic [31:0] word_f;

    assign byte_f = 8'(mem_rdata >> {off, 3'b000});
    assign half_f = 16'(mem_rdata >> {off[2:1], 4'b0000});
    assign word_f = 32'(mem_rdata >> {off[2], 5'b00000});

    always_comb begin
        ext_data = 64'd0;
        case (memdata_width)
            MW_LD:   ext_data = mem_rdata;
            MW_LW:   ext_data = {{32{word_f[31]}}, word_f};
            MW_LH:   ext_data = {{48{half_f[15]}}, half_f};
            MW_LB:   ext_data = {{56{byte_f[7]}}, byte_f};
            MW_LWU:  ext_data = {32'd0, word_f};
            MW_LHU:  ext_data = {48'd0, half_f};
            MW_LBU:  ext_data = {56'd0, byte_f};
            default: ext_data = 64'd0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (memdata_width)
            MW_LD:          misaligned = |off;
            MW_LW, MW_LWU:  misaligned = |off[1:0];
            MW_LH, MW_LHU:  misaligned = off[0];
            default:        misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_data_unit.sv
// Single-outstanding load unit: issues an aligned 8-byte read, extracts and
// extends the addressed field, with misalignment detection and flush/drain.
module load_data_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [2:0]  memdata_width,
    input  logic [63:0] addr,
    input  logic        flush,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        load_done,
    output logic [63:0] load_data,
    output logic        load_err,
    output ld_state_e   dbg_state
);

    // Handshake: a request is taken on a cycle where ld_valid && ld_ready
    // and flush is low; ld_ready is high only in IDLE and never during reset.

    ld_state_e   state, state_next;
    logic [2:0]  width_q;
    logic [2:0]  off_q;
    logic [2:0]  sel_off;
    logic [2:0]  sel_width;
    logic [63:0] ext_data;
    logic        misaligned;
    logic        accept;
    logic        capture;

    // In IDLE the extractor checks the incoming request; afterwards it works
    // on the registered request, so one instance serves both purposes.
    assign sel_off   = (state == S_IDLE) ? addr[2:0] : off_q;
    assign sel_width = (state == S_IDLE) ? memdata_width : width_q;

    load_extract u_extract (
        .mem_rdata     (mem_rdata),
        .off           (sel_off),
        .memdata_width (sel_width),
        .ext_data      (ext_data),
        .misaligned    (misaligned)
    );

    assign ld_ready  = (state == S_IDLE) && !rst;
    assign accept    = ld_valid && ld_ready && !flush;
    assign capture   = (state == S_WAIT) && mem_rvalid && !flush;
    assign load_done = (state == S_DONE) && !flush;
    assign load_err  = (state == S_ERR) && !flush;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_next = S_ERR;
                    end else if (memdata_width == MW_NONE) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A grant coinciding with flush is still owed a response.
                if (flush) begin
                    state_next = mem_gnt ? S_DRAIN : S_IDLE;
                end else if (mem_gnt) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_next = mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid) begin
                    state_next = S_DONE;
                end
            end
            S_DRAIN: begin
                if (mem_rvalid) begin
                    state_next = S_IDLE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            width_q   <= MW_NONE;
            off_q     <= 3'd0;
            mem_req   <= 1'b0;
            mem_addr  <= 64'd0;
            load_data <= 64'd0;
        end else begin
            mem_req <= (state_next == S_REQ);
            if (accept) begin
                width_q  <= memdata_width;
                off_q    <= addr[2:0];
                mem_addr <= {addr[63:3], 3'b000};
                if (memdata_width == MW_NONE) begin
                    load_data <= 64'd0;
                end
            end
            if (capture) begin
                load_data <= ext_data;
            end
        end
    end

endmodule

// File: tb/tb_load_data_unit.sv
// Bench for load_data_unit: directed scenarios plus randomized loads checked
// against a byte-level reference model.
module tb_load_data_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  memdata_width;
    logic [63:0] addr;
    logic        flush;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        load_done;
    logic [63:0] load_data;
    logic        load_err;
    ld_state_e   dbg_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_data;

    load_data_unit dut (
        .clk           (clk),
        .rst           (rst),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .memdata_width (memdata_width),
        .addr          (addr),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .load_done     (load_done),
        .load_data     (load_data),
        .load_err      (load_err),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: assemble the field byte by byte, then extend
    function automatic void ref_load(input logic [2:0] w, input logic [2:0] off,
                                     input logic [63:0] d, output bit err,
                                     output logic [63:0] v);
        int  size;
        bit  sgn;
        size = 0;
        sgn  = 1'b0;
        case (w)
            3'd1: size = 8;
            3'd2: begin size = 4; sgn = 1'b1; end
            3'd3: begin size = 2; sgn = 1'b1; end
            3'd4: begin size = 1; sgn = 1'b1; end
            3'd5: size = 4;
            3'd6: size = 2;
            3'd7: size = 1;
            default: size = 0;
        endcase
        err = (size != 0) && ((int'(off) % size) != 0);
        v = 64'd0;
        if (!err) begin
            for (int i = 0; i < size; i++) begin
                v[8*i +: 8] = d[8*(int'(off)+i) +: 8];
            end
            if (sgn && v[8*size-1]) begin
                for (int i = 8*size; i < 64; i++) v[i] = 1'b1;
            end
        end
    endfunction

    // driver tasks
    task automatic quiet_inputs();
        ld_valid      = 1'b0;
        memdata_width = 3'd0;
        addr          = 64'd0;
        flush         = 1'b0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 64'd0;
    endtask

    task automatic accept_req(input logic [2:0] w, input logic [63:0] a);
        ld_valid      = 1'b1;
        memdata_width = w;
        addr          = a;
        tick();
        ld_valid      = 1'b0;
        memdata_width = 3'($urandom_range(0, 7));
        addr          = {$urandom, $urandom};
    endtask

    task automatic do_load(input logic [2:0] w, input logic [63:0] a,
                           input logic [63:0] d, input int gd, input int rd);
        bit          err;
        logic [63:0] v;
        ref_load(w, a[2:0], d, err, v);
        check("ready_before", {63'd0, ld_ready}, 64'd1);
        accept_req(w, a);
        if (err) begin
            check("err_pulse", {63'd0, load_err}, 64'd1);
            check("err_noreq", {63'd0, mem_req}, 64'd0);
            check("err_nodone", {63'd0, load_done}, 64'd0);
            tick();
            check("err_ready", {63'd0, ld_ready}, 64'd1);
            check("err_end", {63'd0, load_err}, 64'd0);
            check("err_hold", load_data, model_data);
        end else if (w == MW_NONE) begin
            check("none_done", {63'd0, load_done}, 64'd1);
            check("none_data", load_data, 64'd0);
            check("none_noreq", {63'd0, mem_req}, 64'd0);
            model_data = 64'd0;
            tick();
            check("none_ready", {63'd0, ld_ready}, 64'd1);
        end else begin
            for (int i = 0; i < gd; i++) begin
                check("req_hold", {63'd0, mem_req}, 64'd1);
                check("req_addr", mem_addr, {a[63:3], 3'b000});
                tick();
            end
            check("req_on", {63'd0, mem_req}, 64'd1);
            check("req_addr", mem_addr, {a[63:3], 3'b000});
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            check("gnt_drop", {63'd0, mem_req}, 64'd0);
            for (int i = 0; i < rd; i++) begin
                check("wait_nodone", {63'd0, load_done}, 64'd0);
                check("wait_busy", {63'd0, ld_ready}, 64'd0);
                tick();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = d;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
            exp_q.push_back(v);
            check("done_pulse", {63'd0, load_done}, 64'd1);
            if (exp_q.size() > 0) check("load_data", load_data, exp_q.pop_front());
            model_data = v;
            tick();
            check("done_end", {63'd0, load_done}, 64'd0);
            check("data_hold", load_data, model_data);
            check("ready_after", {63'd0, ld_ready}, 64'd1);
        end
    endtask

    initial begin
        quiet_inputs();
        model_data = 64'd0;

        // reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ready", {63'd0, ld_ready}, 64'd0);
        check("rst_req", {63'd0, mem_req}, 64'd0);
        check("rst_done", {63'd0, load_done}, 64'd0);
        check("rst_err", {63'd0, load_err}, 64'd0);
        check("rst_data", load_data, 64'd0);
        check("rst_addr", mem_addr, 64'd0);
        check("rst_state", {61'd0, dbg_state}, {61'd0, S_IDLE});
        rst = 1'b0;
        #1;
        check("ready_post_rst", {63'd0, ld_ready}, 64'd1);
        tick();

        // directed loads
        do_load(MW_LB,  64'h1007, 64'h80FF_FFFF_FFFF_FFFF, 0, 0);
        check("lb_val", load_data, 64'hFFFF_FFFF_FFFF_FF80);
        do_load(MW_LHU, 64'h2006, 64'hBEEF_0000_0000_0000, 0, 0);
        check("lhu_val", load_data, 64'h0000_0000_0000_BEEF);
        do_load(MW_LH,  64'h2006, 64'hBEEF_0000_0000_0000, 1, 1);
        check("lh_val", load_data, 64'hFFFF_FFFF_FFFF_BEEF);
        do_load(MW_LW,  64'h2002, 64'h1234_5678_9ABC_DEF0, 0, 0);
        do_load(MW_LD,  64'h3000, 64'h0123_4567_89AB_CDEF, 0, 0);
        check("ld_val", load_data, 64'h0123_4567_89AB_CDEF);
        do_load(MW_LWU, 64'h3004, 64'hF000_0001_8000_0002, 4, 2);
        check("lwu_val", load_data, 64'h0000_0000_F000_0001);
        do_load(MW_NONE, 64'h5555, 64'h0, 0, 0);
        do_load(MW_LD,  64'h3003, 64'h0, 0, 0);

        // flush in IDLE: no accept
        ld_valid = 1'b1; memdata_width = MW_LD; addr = 64'h6000; flush = 1'b1;
        tick();
        quiet_inputs();
        check("fidle_req", {63'd0, mem_req}, 64'd0);
        check("fidle_ready", {63'd0, ld_ready}, 64'd1);

        // flush in REQ without grant
        accept_req(MW_LD, 64'h6000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("freq_req", {63'd0, mem_req}, 64'd0);
        check("freq_ready", {63'd0, ld_ready}, 64'd1);

        // flush in REQ with grant: drain
        accept_req(MW_LD, 64'h6008);
        flush = 1'b1; mem_gnt = 1'b1;
        tick();
        flush = 1'b0; mem_gnt = 1'b0;
        check("fgnt_req", {63'd0, mem_req}, 64'd0);
        check("fgnt_busy", {63'd0, ld_ready}, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        check("fgnt_ready", {63'd0, ld_ready}, 64'd1);
        check("fgnt_nodone", {63'd0, load_done}, 64'd0);
        check("fgnt_hold", load_data, model_data);

        // flush in WAIT, response two cycles later
        accept_req(MW_LD, 64'h7000);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fwait_busy1", {63'd0, ld_ready}, 64'd0);
        check("fwait_nodone1", {63'd0, load_done}, 64'd0);
        tick();
        check("fwait_busy2", {63'd0, ld_ready}, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
        tick();
        mem_rvalid = 1'b0;
        check("fwait_ready", {63'd0, ld_ready}, 64'd1);
        check("fwait_nodone", {63'd0, load_done}, 64'd0);
        check("fwait_hold", load_data, model_data);

        // flush in WAIT with response in the same cycle
        accept_req(MW_LD, 64'h7008);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h5555_6666_7777_8888;
        tick();
        flush = 1'b0; mem_rvalid = 1'b0;
        check("fwrv_ready", {63'd0, ld_ready}, 64'd1);
        check("fwrv_nodone", {63'd0, load_done}, 64'd0);
        check("fwrv_hold", load_data, model_data);

        // flush in ERR suppresses the pulse
        accept_req(MW_LH, 64'h8001);
        flush = 1'b1;
        #1;
        check("ferr_nopulse", {63'd0, load_err}, 64'd0);
        tick();
        flush = 1'b0;
        check("ferr_ready", {63'd0, ld_ready}, 64'd1);

        // reset in WAIT, then stale response in IDLE is ignored
        accept_req(MW_LD, 64'h9008);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        check("rwait_ready", {63'd0, ld_ready}, 64'd0);
        check("rwait_req", {63'd0, mem_req}, 64'd0);
        check("rwait_done", {63'd0, load_done}, 64'd0);
        check("rwait_err", {63'd0, load_err}, 64'd0);
        check("rwait_data", load_data, 64'd0);
        check("rwait_addr", mem_addr, 64'd0);
        model_data = 64'd0;
        rst = 1'b0;
        tick();
        check("rwait_ready2", {63'd0, ld_ready}, 64'd1);
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        check("stale_nodone", {63'd0, load_done}, 64'd0);
        check("stale_req", {63'd0, mem_req}, 64'd0);
        check("stale_ready", {63'd0, ld_ready}, 64'd1);
        check("stale_hold", load_data, model_data);
        do_load(MW_LBU, 64'hA005, 64'h0000_9A00_0000_0000, 1, 0);
        check("lbu_val", load_data, 64'h0000_0000_0000_009A);

        // randomized loads against the reference model
        for (int n = 0; n < 80; n++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) a[2:0] = a[2:0] & 3'(~($urandom_range(0, 7)));
            do_load(3'($urandom_range(0, 7)), a, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
